// File: rtl/profiler_pkg.sv
// ---------------------------------------------------------------------------
// profiler_pkg
// Shared types and helpers for the ap_ctrl handshake transaction profiler.
//
// Contents:
//   PROF_CNT_W / PROF_ID_W : default counter and transaction id widths
//   DROP_W                 : width of the saturating dropped-record counter
//   prof_rec_t             : record layout {txn_id, latency, interval, stall}
//                            at the default widths, as seen by the
//                            module-status dump path
//   outst_ent_t            : outstanding-transaction layout
//                            {t_s, id, interval, stall} at the default widths
//   sat_inc_drop()         : saturating increment for the drop counter
//
// The profiler top declares same-shaped types sized by its own CNT_W/ID_W
// parameters, so non-default widths stay consistent inside the block.
// ---------------------------------------------------------------------------
package profiler_pkg;

  localparam int PROF_CNT_W = 32;
  localparam int PROF_ID_W  = 16;
  localparam int DROP_W     = 16;

  typedef struct packed {
    logic [PROF_ID_W-1:0]  txn_id;
    logic [PROF_CNT_W-1:0] latency;
    logic [PROF_CNT_W-1:0] interval;
    logic [PROF_CNT_W-1:0] stall;
  } prof_rec_t;

  typedef struct packed {
    logic [PROF_CNT_W-1:0] t_s;
    logic [PROF_ID_W-1:0]  id;
    logic [PROF_CNT_W-1:0] interval;
    logic [PROF_CNT_W-1:0] stall;
  } outst_ent_t;

  // Counts up and sticks at all-ones instead of wrapping back to zero.
  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/prof_sync_fifo.sv
// ---------------------------------------------------------------------------
// prof_sync_fifo
// Single-clock first-word-fall-through FIFO with a parameterised element type.
// The head element is visible on rdata whenever empty=0. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; pops on an
// empty FIFO are ignored.
//
// Parameters:
//   T      element type
//   DEPTH  number of entries, power of 2, at least 2
//
// Ports:
//   ap_clk    in   clock
//   ap_rst_n  in   asynchronous active-low reset (pointers and count only)
//   push      in   write wdata
//   pop       in   discard the head element
//   wdata     in   element to write
//   rdata     out  head element (undefined while empty)
//   full      out  DEPTH elements stored
//   empty     out  no element stored
// ---------------------------------------------------------------------------
module prof_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;

  T               mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == DEPTH_U[AW:0]);
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // Storage needs no reset; only occupied slots are ever presented.
  always_ff @(posedge ap_clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// ---------------------------------------------------------------------------
// ap_ctrl_txn_profiler
// Non-intrusive observer of an HLS ap_ctrl_hs / ap_ctrl_chain handshake.
// Timestamps each transaction with a free-running cycle counter and emits one
// record per completed transaction (id, start-to-done latency, start-to-start
// interval) on a valid/ready stream backed by a FWFT record FIFO.
//
// Optional feature macro: PROFILER_STALL_CNT_EN
//   defined   : count mon_ap_done=1 & mon_ap_continue=0 cycles against the
//               head outstanding transaction, reported on rec_stall
//               (saturating)
//   undefined : no stall logic, rec_stall is constant 0
//
// Ports:
//   ap_clk, ap_rst_n     clock, asynchronous active-low reset
//   enable               0 = ignore handshake events (counter keeps running)
//   mon_ap_start/ready/done/continue   observed handshake signals
//   rec_valid/rec_ready  record stream handshake
//   rec_txn_id           transaction id (wraps modulo 2^ID_W)
//   rec_latency          t_done - t_start
//   rec_interval         t_start(n) - t_start(n-1), 0 for the first one
//   rec_stall            done-backpressure cycles (optional feature)
//   drop_count           records lost to a full record FIFO, saturating
//   err_outst_ovf        sticky: accept while outstanding FIFO full
//   err_orphan_done      sticky: done with nothing outstanding
//   busy                 outstanding FIFO not empty
// ---------------------------------------------------------------------------
module ap_ctrl_txn_profiler
  import profiler_pkg::*;
#(
  parameter int CNT_W       = PROF_CNT_W,
  parameter int ID_W        = PROF_ID_W,
  parameter int OUTST_DEPTH = 4,
  parameter int REC_DEPTH   = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              enable,
  input  logic              mon_ap_start,
  input  logic              mon_ap_ready,
  input  logic              mon_ap_done,
  input  logic              mon_ap_continue,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [ID_W-1:0]   rec_txn_id,
  output logic [CNT_W-1:0]  rec_latency,
  output logic [CNT_W-1:0]  rec_interval,
  output logic [CNT_W-1:0]  rec_stall,
  output logic [DROP_W-1:0] drop_count,
  output logic              err_outst_ovf,
  output logic              err_orphan_done,
  output logic              busy
);

  // Same shapes as outst_ent_t / prof_rec_t, sized by this instance. The
  // stall count only ever accumulates for the head entry, so it lives in one
  // register rather than in every outstanding slot.
  typedef struct packed {
    logic [CNT_W-1:0] t_s;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] interval;
  } ent_t;

  typedef struct packed {
    logic [ID_W-1:0]  txn_id;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] interval;
`ifdef PROFILER_STALL_CNT_EN
    logic [CNT_W-1:0] stall;
`endif
  } rec_t;

  logic [1:0]       rst_sync_q;
  logic             rst_n_int;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] t_cap;
  logic [CNT_W-1:0] t_prev;
  logic [CNT_W-1:0] t_s_now;
  logic [CNT_W-1:0] interval_now;
  logic [ID_W-1:0]  id;
  logic             armed;
  logic             first;

  logic             accept;
  logic             done;
  logic             capture_now;
  logic             bypass;
  logic             orphan;
  logic             outst_ovf;

  logic             o_push;
  logic             o_pop;
  logic             o_full;
  logic             o_empty;
  ent_t             o_wdata;
  ent_t             o_head;

  logic             r_push;
  logic             r_pop;
  logic             r_full;
  logic             r_empty;
  logic             r_drop;
  rec_t             r_wdata;
  rec_t             r_head;

  // Reset asserts immediately but releases two clocks after ap_rst_n rises,
  // so every register leaves reset on the same edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // Handshake events; everything except the counter is frozen while
  // enable is low.
  assign accept      = enable & mon_ap_start & mon_ap_ready;
  assign done        = enable & mon_ap_done & mon_ap_continue;
  assign capture_now = enable & armed & mon_ap_start;

  // A start that is accepted in its first cycle uses the live counter.
  assign t_s_now      = capture_now ? cnt : t_cap;
  assign interval_now = first ? '0 : (t_s_now - t_prev);

  // With nothing outstanding, a done coinciding with an accept completes that
  // accepting transaction directly (latency 0) without touching the FIFO.
  assign bypass    = done & o_empty & accept;
  assign orphan    = done & o_empty & ~accept;
  assign o_pop     = done & ~o_empty;
  assign o_push    = accept & ~bypass & (~o_full | o_pop);
  assign outst_ovf = accept & ~bypass & o_full & ~o_pop;

  assign o_wdata = '{t_s: t_s_now, id: id, interval: interval_now};

  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cnt    <= '0;
      t_cap  <= '0;
      t_prev <= '0;
      id     <= '0;
      armed  <= 1'b1;
      first  <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (capture_now) begin
        t_cap <= cnt;
        armed <= 1'b0;
      end
      // An accept re-arms for the next start even if it also captured.
      if (accept) begin
        armed  <= 1'b1;
        id     <= id + 1'b1;
        t_prev <= t_s_now;
        first  <= 1'b0;
      end
    end
  end

`ifdef PROFILER_STALL_CNT_EN
  logic [CNT_W-1:0] head_stall;

  // A stall cycle has done=1 with continue=0, so it can never coincide with
  // the pop that hands the count to the record.
  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      head_stall <= '0;
    end else if (o_pop) begin
      head_stall <= '0;
    end else if (enable & ~o_empty & mon_ap_done & ~mon_ap_continue & ~(&head_stall)) begin
      head_stall <= head_stall + 1'b1;
    end
  end
`endif

  assign r_push = o_pop | bypass;
  assign r_pop  = rec_ready & ~r_empty;
  assign r_drop = r_push & r_full & ~r_pop;

  always_comb begin
    r_wdata = '0;
    if (bypass) begin
      r_wdata.txn_id   = id;
      r_wdata.latency  = '0;
      r_wdata.interval = interval_now;
    end else begin
      r_wdata.txn_id   = o_head.id;
      r_wdata.latency  = cnt - o_head.t_s;
      r_wdata.interval = o_head.interval;
`ifdef PROFILER_STALL_CNT_EN
      r_wdata.stall    = head_stall;
`endif
    end
  end

  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      err_outst_ovf   <= 1'b0;
      err_orphan_done <= 1'b0;
      drop_count      <= '0;
    end else begin
      if (outst_ovf) begin
        err_outst_ovf <= 1'b1;
      end
      if (orphan) begin
        err_orphan_done <= 1'b1;
      end
      if (r_drop) begin
        drop_count <= sat_inc_drop(drop_count);
      end
    end
  end

  prof_sync_fifo #(
    .T     (ent_t),
    .DEPTH (OUTST_DEPTH)
  ) u_outst_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (rst_n_int),
    .push     (o_push),
    .pop      (o_pop),
    .wdata    (o_wdata),
    .rdata    (o_head),
    .full     (o_full),
    .empty    (o_empty)
  );

  prof_sync_fifo #(
    .T     (rec_t),
    .DEPTH (REC_DEPTH)
  ) u_rec_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (rst_n_int),
    .push     (r_push),
    .pop      (r_pop),
    .wdata    (r_wdata),
    .rdata    (r_head),
    .full     (r_full),
    .empty    (r_empty)
  );

  // Data is forced to zero while no record is held, so reset and idle both
  // present clean zeros instead of stale FIFO contents.
  assign rec_valid    = ~r_empty;
  assign rec_txn_id   = r_empty ? '0 : r_head.txn_id;
  assign rec_latency  = r_empty ? '0 : r_head.latency;
  assign rec_interval = r_empty ? '0 : r_head.interval;
`ifdef PROFILER_STALL_CNT_EN
  assign rec_stall    = r_empty ? '0 : r_head.stall;
`else
  assign rec_stall    = '0;
`endif
  assign busy         = ~o_empty;

endmodule
